// File: rtl/bdos_pkg.sv
// Shared constants for the hardware CP/M BDOS console trap: FSM state codes,
// BDOS function numbers and ASCII control characters.
package bdos_pkg;

    typedef logic [2:0] bdos_state_t;

    localparam bdos_state_t ST_IDLE = 3'd0;
    localparam bdos_state_t ST_CHAR = 3'd1;
    localparam bdos_state_t ST_RD   = 3'd2;
    localparam bdos_state_t ST_WAIT = 3'd3;
    localparam bdos_state_t ST_EMIT = 3'd4;
    localparam bdos_state_t ST_DONE = 3'd5;

    localparam logic [7:0] BDOS_CONOUT   = 8'd2;
    localparam logic [7:0] BDOS_PRINTSTR = 8'd9;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

endpackage

// File: rtl/bdos_console_out_stage.sv
// Output holding register for the console byte stream: data stays stable
// while valid is high and the sink is not ready; handshake clears valid.
module bdos_out_stage (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic       ready_i,
    output logic [7:0] data_o,
    output logic       valid_o
);

    logic [7:0] data_q;
    logic       valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/bdos_console.sv
// BDOS console trap: holds the i8080 on a fetch from BDOS_ENTRY and services
// C=2 / C=9 in hardware. Optional LF -> CR,LF expansion: BDOS_CRLF_EXPAND_EN.
module bdos_console
    import bdos_pkg::*;
#(
    parameter logic [15:0] BDOS_ENTRY = 16'h0005,
    parameter logic [7:0]  TERMINATOR = 8'h24,
    parameter int unsigned MAX_LEN    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m1,
    input  logic [15:0] pc,
    input  logic [7:0]  reg_c,
    input  logic [7:0]  reg_d,
    input  logic [7:0]  reg_e,
    output logic        cpu_hold,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        err_call
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    bdos_state_t      state_q, state_d;
    logic [15:0]      addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d, len_inc;
    logic             err_q, err_d;
    logic             trap, hs, load;
    logic [7:0]       load_data;
`ifdef BDOS_CRLF_EXPAND_EN
    logic             lf_pend_q, lf_pend_d;
`endif

    assign trap     = m1 && (pc == BDOS_ENTRY) && (state_q == ST_IDLE);
    assign hs       = tx_valid && tx_ready;
    assign cpu_hold = trap || (state_q != ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign mem_rd   = (state_q == ST_RD);
    assign mem_addr = addr_q;
    assign err_call = err_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        err_d     = 1'b0;
        load      = 1'b0;
        load_data = '0;
        len_inc   = len_q + LEN_W'(1);
`ifdef BDOS_CRLF_EXPAND_EN
        lf_pend_d = lf_pend_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (trap) begin
                    case (reg_c)
                        BDOS_CONOUT: begin
                            load      = 1'b1;
                            load_data = reg_e;
                            state_d   = ST_CHAR;
                        end
                        BDOS_PRINTSTR: begin
                            addr_d  = {reg_d, reg_e};
                            len_d   = '0;
                            state_d = ST_RD;
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = ST_DONE;
                        end
                    endcase
                end
            end
            ST_CHAR: begin
                if (hs) begin
`ifdef BDOS_CRLF_EXPAND_EN
                    if (lf_pend_q) begin
                        load      = 1'b1;
                        load_data = LF;
                        lf_pend_d = 1'b0;
                    end else
`endif
                    state_d = ST_DONE;
                end
            end
            ST_RD: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mem_rdata == TERMINATOR) begin
                    state_d = ST_DONE;
                end else begin
                    load      = 1'b1;
                    load_data = mem_rdata;
                    state_d   = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (hs) begin
`ifdef BDOS_CRLF_EXPAND_EN
                    // The inserted CR is not a string byte: no address/length step.
                    if (lf_pend_q) begin
                        load      = 1'b1;
                        load_data = LF;
                        lf_pend_d = 1'b0;
                    end else
`endif
                    begin
                        addr_d = addr_q + 16'd1;
                        len_d  = len_inc;
                        if (len_inc == LEN_W'(MAX_LEN)) begin
                            err_d   = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RD;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
`ifdef BDOS_CRLF_EXPAND_EN
        // A fresh LF is sent as CR first; the LF follows from the pending flag.
        if (load && !lf_pend_q && (load_data == LF)) begin
            load_data = CR;
            lf_pend_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

`ifdef BDOS_CRLF_EXPAND_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lf_pend_q <= 1'b0;
        end else begin
            lf_pend_q <= lf_pend_d;
        end
    end
`endif

    bdos_out_stage u_out (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .data_i  (load_data),
        .ready_i (tx_ready),
        .data_o  (tx_data),
        .valid_o (tx_valid)
    );

endmodule

// File: tb/tb_bdos_console.sv
// Directed self-checking bench for bdos_console (default and MAX_LEN=4 instances).
module tb_bdos_console;

    logic        clk = 1'b0;
    logic        rst;
    logic        m1, m1_b;
    logic [15:0] pc;
    logic [7:0]  reg_c, reg_d, reg_e;
    logic        tx_ready;

    logic        cpu_hold, mem_rd, tx_valid, busy, err_call;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata, tx_data;
    logic        cpu_hold_b, mem_rd_b, tx_valid_b, busy_b, err_call_b;
    logic [15:0] mem_addr_b;
    logic [7:0]  mem_rdata_b, tx_data_b;

    logic [7:0]  mem [0:65535];
    logic [7:0]  rx[$];
    logic [7:0]  rx4[$];
    int          err_cnt = 0;
    int          err4_cnt = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    bdos_console u_dut (
        .clk(clk), .rst(rst), .m1(m1), .pc(pc),
        .reg_c(reg_c), .reg_d(reg_d), .reg_e(reg_e),
        .cpu_hold(cpu_hold), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .err_call(err_call)
    );

    bdos_console #(.MAX_LEN(4)) u_dut4 (
        .clk(clk), .rst(rst), .m1(m1_b), .pc(pc),
        .reg_c(reg_c), .reg_d(reg_d), .reg_e(reg_e),
        .cpu_hold(cpu_hold_b), .mem_addr(mem_addr_b), .mem_rd(mem_rd_b),
        .mem_rdata(mem_rdata_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready), .busy(busy_b), .err_call(err_call_b)
    );

    always @(posedge clk) begin
        if (mem_rd)   mem_rdata   <= mem[mem_addr];
        if (mem_rd_b) mem_rdata_b <= mem[mem_addr_b];
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (tx_valid && tx_ready)   rx.push_back(tx_data);
            if (tx_valid_b && tx_ready) rx4.push_back(tx_data_b);
            if (err_call)   err_cnt++;
            if (err_call_b) err4_cnt++;
        end
    end

    task automatic do_trap(input logic [7:0] c, input logic [15:0] de, input bit sel);
        @(negedge clk);
        pc = 16'h0005; reg_c = c; reg_d = de[15:8]; reg_e = de[7:0];
        if (sel) m1_b = 1'b1; else m1 = 1'b1;
        #1;
        total++;
        if ((sel ? cpu_hold_b : cpu_hold) !== 1'b1) begin
            bad++; $display("FAIL trap_hold: got %0b want 1", sel ? cpu_hold_b : cpu_hold);
        end
        @(negedge clk);
        m1 = 1'b0; m1_b = 1'b0; pc = 16'h1234;
    endtask

    task automatic wait_idle(input bit sel, output int n);
        n = 0;
        while ((sel ? busy_b : busy) && n < 400) begin
            @(negedge clk); n++;
        end
        total++;
        if (sel ? busy_b : busy) begin
            bad++; $display("FAIL idle_timeout: got busy=1 want 0 after %0d cycles", n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; m1 = 1'b0; m1_b = 1'b0; pc = '0; reg_c = '0; reg_d = '0; reg_e = '0;
        tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({tx_valid, cpu_hold, busy, err_call, mem_rd} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 00000", {tx_valid, cpu_hold, busy, err_call, mem_rd});
        end
        total++;
        if ({mem_addr, tx_data} !== 24'h0) begin
            bad++; $display("FAIL reset_data: got %h want 000000", {mem_addr, tx_data});
        end
        rst = 1'b0;
    endtask

    task automatic test_conout;
        int n;
        tx_ready = 1'b1; rx.delete();
        do_trap(8'd2, 16'h0041, 1'b0);
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
            bad++; $display("FAIL conout_t1: got v=%0b d=%h want v=1 d=41", tx_valid, tx_data);
        end
        @(negedge clk);
        total++;
        if (tx_valid !== 1'b0 || cpu_hold !== 1'b1) begin
            bad++; $display("FAIL conout_t2: got v=%0b hold=%0b want v=0 hold=1", tx_valid, cpu_hold);
        end
        @(negedge clk);
        total++;
        if (cpu_hold !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL conout_t3: got hold=%0b busy=%0b want 0 0", cpu_hold, busy);
        end
        total++;
        if (rx.size() != 1 || rx[0] !== 8'h41) begin
            bad++; $display("FAIL conout_bytes: got n=%0d want 1 byte 41", rx.size());
        end
        rx.delete();
        do_trap(8'd2, 16'h000A, 1'b0);
        wait_idle(1'b0, n);
`ifdef BDOS_CRLF_EXPAND_EN
        total++;
        if (rx.size() != 2 || rx[0] !== 8'h0D || rx[1] !== 8'h0A) begin
            bad++; $display("FAIL conout_lf: got n=%0d want 0D 0A", rx.size());
        end
`else
        total++;
        if (rx.size() != 1 || rx[0] !== 8'h0A) begin
            bad++; $display("FAIL conout_lf: got n=%0d want 0A", rx.size());
        end
`endif
    endtask

    task automatic test_printstr;
        int n;
        int e0;
        mem[16'h0200] = 8'h48; mem[16'h0201] = 8'h49; mem[16'h0202] = 8'h24;
        mem[16'h0300] = 8'h24;
        tx_ready = 1'b1; rx.delete(); e0 = err_cnt;
        do_trap(8'd9, 16'h0200, 1'b0);
        total++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0200) begin
            bad++; $display("FAIL str_rd: got rd=%0b a=%h want 1 0200", mem_rd, mem_addr);
        end
        wait_idle(1'b0, n);
        total++;
        if (n + 1 != 10) begin
            bad++; $display("FAIL str_hold_len: got %0d want 10", n + 1);
        end
        total++;
        if (rx.size() != 2 || rx[0] !== 8'h48 || rx[1] !== 8'h49) begin
            bad++; $display("FAIL str_bytes: got n=%0d want 48 49", rx.size());
        end
        total++;
        if (err_cnt != e0) begin
            bad++; $display("FAIL str_err: got %0d pulses want 0", err_cnt - e0);
        end
        rx.delete();
        do_trap(8'd9, 16'h0300, 1'b0);
        wait_idle(1'b0, n);
        total++;
        if (n + 1 != 4 || rx.size() != 0) begin
            bad++; $display("FAIL str_empty: got hold=%0d n=%0d want hold=4 n=0", n + 1, rx.size());
        end
    endtask

    task automatic test_random_ready;
        logic       pv, pr;
        logic [7:0] pd;
        int         n;
        for (int i = 0; i < 5; i++) mem[16'h0400 + i] = 8'h41 + 8'(i);
        mem[16'h0405] = 8'h24;
        rx.delete(); tx_ready = 1'b0; pv = 1'b0; pr = 1'b0; pd = '0; n = 0;
        do_trap(8'd9, 16'h0400, 1'b0);
        while (busy && n < 300) begin
            if (pv && !pr) begin
                total++;
                if (tx_valid !== 1'b1 || tx_data !== pd) begin
                    bad++; $display("FAIL rnd_stable: got v=%0b d=%h want v=1 d=%h", tx_valid, tx_data, pd);
                end
            end
            pv = tx_valid; pd = tx_data;
            tx_ready = 1'($urandom_range(0, 1));
            pr = tx_ready;
            @(negedge clk); n++;
        end
        tx_ready = 1'b1;
        total++;
        if (busy) begin
            bad++; $display("FAIL rnd_timeout: got busy=1 want 0");
        end
        total++;
        if (rx.size() != 5) begin
            bad++; $display("FAIL rnd_count: got %0d want 5", rx.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (rx[i] !== 8'h41 + 8'(i)) begin
                    bad++; $display("FAIL rnd_byte%0d: got %h want %h", i, rx[i], 8'h41 + 8'(i));
                end
            end
        end
    endtask

    task automatic test_wrap;
        logic [15:0] addrs[$];
        int n;
        mem[16'hFFFF] = 8'h41; mem[16'h0000] = 8'h24;
        rx.delete(); tx_ready = 1'b1; n = 0;
        do_trap(8'd9, 16'hFFFF, 1'b0);
        while (busy && n < 50) begin
            if (mem_rd) addrs.push_back(mem_addr);
            @(negedge clk); n++;
        end
        total++;
        if (addrs.size() != 2 || addrs[0] !== 16'hFFFF || addrs[1] !== 16'h0000) begin
            bad++; $display("FAIL wrap_addr: got n=%0d want FFFF then 0000", addrs.size());
        end
        total++;
        if (rx.size() != 1 || rx[0] !== 8'h41) begin
            bad++; $display("FAIL wrap_bytes: got n=%0d want 41 only", rx.size());
        end
    endtask

    task automatic test_bad_call;
        int e0;
        rx.delete(); tx_ready = 1'b1; e0 = err_cnt;
        do_trap(8'd7, 16'h0041, 1'b0);
        total++;
        if (err_call !== 1'b1 || tx_valid !== 1'b0) begin
            bad++; $display("FAIL bad_t1: got err=%0b v=%0b want 1 0", err_call, tx_valid);
        end
        @(negedge clk);
        total++;
        if (err_call !== 1'b0 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL bad_t2: got err=%0b hold=%0b busy=%0b want 0 0 0", err_call, cpu_hold, busy);
        end
        total++;
        if (err_cnt - e0 != 1 || rx.size() != 0) begin
            bad++; $display("FAIL bad_summary: got pulses=%0d bytes=%0d want 1 0", err_cnt - e0, rx.size());
        end
    endtask

    task automatic test_maxlen;
        int n;
        int e0;
        for (int i = 0; i < 8; i++) mem[16'h0500 + i] = 8'h41 + 8'(i);
        rx4.delete(); tx_ready = 1'b1; e0 = err4_cnt;
        do_trap(8'd9, 16'h0500, 1'b1);
        wait_idle(1'b1, n);
        total++;
        if (rx4.size() != 4 || rx4[0] !== 8'h41 || rx4[3] !== 8'h44) begin
            bad++; $display("FAIL maxlen_bytes: got n=%0d want 41..44", rx4.size());
        end
        total++;
        if (err4_cnt - e0 != 1) begin
            bad++; $display("FAIL maxlen_err: got %0d pulses want 1", err4_cnt - e0);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        mem[16'h0200] = 8'h48; mem[16'h0201] = 8'h49; mem[16'h0202] = 8'h24;
        rx.delete(); tx_ready = 1'b0; n = 0;
        do_trap(8'd9, 16'h0200, 1'b0);
        while (!tx_valid && n < 10) begin
            @(negedge clk); n++;
        end
        total++;
        if (tx_valid !== 1'b1) begin
            bad++; $display("FAIL rstmid_emit: got v=%0b want 1", tx_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (tx_valid !== 1'b0 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_state: got v=%0b hold=%0b busy=%0b want 0 0 0", tx_valid, cpu_hold, busy);
        end
        rst = 1'b0; tx_ready = 1'b1; rx.delete();
        do_trap(8'd2, 16'h005A, 1'b0);
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h5A) begin
            bad++; $display("FAIL rstmid_after: got v=%0b d=%h want 1 5A", tx_valid, tx_data);
        end
        wait_idle(1'b0, n);
        total++;
        if (rx.size() != 1 || rx[0] !== 8'h5A) begin
            bad++; $display("FAIL rstmid_bytes: got n=%0d want 5A only", rx.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h2E;
        test_reset();
        test_conout();
        test_printstr();
        test_random_ready();
        test_wrap();
        test_bad_call();
        test_maxlen();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bdos_console.md
Name: bdos_console

Overview:
- Hardware CP/M BDOS console trap, placed between the i8080 core and the system UART transmitter.
- Snoops opcode fetches. On a fetch from the BDOS entry address, it holds the CPU and services console calls in hardware:
  - C=2: output the character in E.
  - C=9: output the '$'-terminated string at DE.
- Characters go out on a valid/ready byte stream. The ROM at the entry address holds RET, so the CPU resumes normally once the hold is released.

Parameters:
- BDOS_ENTRY, 16'h0005, fetch address that triggers a trap.
- TERMINATOR, 8'h24, string terminator ('$').
- MAX_LEN, 1024, maximum bytes emitted per C=9 call before forced abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; synchronous, active-high.
- m1  in  1  one-cycle strobe at start of each opcode fetch.
- pc  in  16  fetch address, valid when m1=1.
- reg_c  in  8  CPU register C, valid when m1=1.
- reg_d  in  8  CPU register D, valid when m1=1.
- reg_e  in  8  CPU register E, valid when m1=1.
- cpu_hold  out  1  stalls the CPU while high.
- mem_addr  out  16  RAM read address.
- mem_rd  out  1  RAM read strobe.
- mem_rdata  in  8  RAM data, valid exactly 1 cycle after mem_rd.
- tx_data  out  8  output character.
- tx_valid  out  1  character valid.
- tx_ready  in  1  sink accepts the character when tx_valid & tx_ready.
- busy  out  1  state != IDLE.
- err_call  out  1  one-cycle pulse on unsupported C, or on MAX_LEN abort.

Behaviour:
- Reset values: all outputs 0, state IDLE, address and length counters 0. Reset mid-call returns to IDLE next cycle and drops tx_valid and cpu_hold. This is the only case where tx_valid may fall without a handshake.
- Trap condition: m1 & (pc == BDOS_ENTRY) & state == IDLE.
- cpu_hold = trap | (state != IDLE). It is combinational, so the CPU never advances past the trapping fetch.
- States: IDLE, CHAR, RD, WAIT, EMIT, DONE.
- IDLE transitions on trap:
  - C=2: latch E into tx_data, go to CHAR.
  - C=9: latch DE into the address counter, clear the length counter, go to RD.
  - Other C: pulse err_call, go to DONE.
- CHAR: tx_valid=1 with tx_data stable; on handshake go to DONE. First tx_valid appears 1 cycle after the trap.
- RD: mem_rd=1, mem_addr=address counter; go to WAIT.
- WAIT: sample mem_rdata.
  - If it equals TERMINATOR, go to DONE; the terminator is never emitted.
  - Otherwise load tx_data and go to EMIT.
- EMIT: hold tx_valid and tx_data until tx_ready.
  - On handshake: increment address (16-bit wrap, 16'hFFFF -> 16'h0000) and length.
  - If length == MAX_LEN: pulse err_call, go to DONE. Otherwise go to RD.
- DONE: one cycle; cpu_hold deasserts the following cycle; go to IDLE.
- Throughput: one byte per 3 cycles when tx_ready is held high.
- m1 while not IDLE is ignored. This cannot occur in normal operation because the CPU is held.
- An empty string (first byte '$') emits nothing; hold lasts 4 cycles (trap, RD, WAIT, DONE).

Optional Feature:
- Macro: BDOS_CRLF_EXPAND_EN.
- Defined: each emitted 0x0A is preceded by 0x0D, using one extra EMIT sub-state. Applies to C=2 and C=9. The extra 0x0D does not count toward MAX_LEN.
- Undefined: bytes pass through unchanged.

Decomposition:
- Package bdos_pkg holds:
  - state enum.
  - function codes BDOS_CONOUT=2, BDOS_PRINTSTR=9.
  - ASCII constants CR=8'h0D, LF=8'h0A.
- One sub-module, bdos_out_stage: the tx_data/tx_valid holding register with load and handshake-clear. It guarantees data stability while valid and not ready.

Test Plan:
- C=2, E=8'h41, tx_ready=1 -> tx_valid at trap+1 with 8'h41, exactly one byte; cpu_hold low at trap+3.
- C=9, DE=16'h0200, RAM "HI$" -> bytes 8'h48, 8'h49 emitted in order; no 8'h24 emitted; err_call stays 0.
- C=9 with tx_ready toggling 0/1 randomly -> tx_data stable while tx_valid & !tx_ready; no byte lost or duplicated.
- C=9, DE=16'hFFFF, mem[FFFF]=8'h41, mem[0000]=8'h24 -> emits 8'h41 only; mem_addr wraps to 16'h0000.
- C=7 -> err_call pulse at trap+1, no tx_valid, hold released; also MAX_LEN=4 with an unterminated string -> 4 bytes then err_call.
- rst asserted during EMIT -> next cycle tx_valid=0, cpu_hold=0, busy=0; a following C=2 call operates normally.
